muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit: radix-2 shift-add and restoring divide.
// Optional signed ops (mult/div) with a sign-fix cycle enabled by MULDIV_SIGNED_EN.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
`ifdef MULDIV_SIGNED_EN
    FIX,
`endif
    DZERO
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic [31:0] m;
  logic [31:0] a_lat;
  logic [63:0] acc;

  logic        sgn_op;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [32:0] add;
  logic [32:0] rem_t;
  logic [32:0] diff;
  logic [63:0] acc_nx;

`ifdef MULDIV_SIGNED_EN
  logic        sgn_q;
  logic        sa_q;
  logic        sb_q;
  logic [63:0] neg_acc;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign sgn_op = op[1];
`else
  logic        unused_op1;

  assign sgn_op     = 1'b0;
  assign unused_op1 = op[1];
`endif

  // Both datapaths run on magnitudes; signs are reapplied afterwards.
  assign ma = (sgn_op && a[31]) ? -a : a;
  assign mb = (sgn_op && b[31]) ? -b : b;

  always_comb begin
    add    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    rem_t  = acc[63:31];
    diff   = rem_t - {1'b0, m};
    acc_nx = {add, acc[31:1]};
    if (is_div) begin
      if (!diff[32])
        acc_nx = {diff[31:0], acc[30:0], 1'b1};
      else
        acc_nx = {rem_t[31:0], acc[30:0], 1'b0};
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_comb begin
    neg_acc = -acc;
    fix_hi  = acc[63:32];
    fix_lo  = acc[31:0];
    if (is_div) begin
      if (sa_q ^ sb_q)
        fix_lo = -acc[31:0];
      if (sa_q)
        fix_hi = -acc[63:32];
    end else if (sa_q ^ sb_q) begin
      fix_hi = neg_acc[63:32];
      fix_lo = neg_acc[31:0];
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      m      <= 32'd0;
      a_lat  <= 32'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_q  <= 1'b0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_lat  <= a;
            is_div <= op[0];
            dz     <= 1'b0;
            busy   <= 1'b1;
            cnt    <= 5'd0;
`ifdef MULDIV_SIGNED_EN
            sgn_q  <= op[1];
            sa_q   <= op[1] & a[31];
            sb_q   <= op[1] & b[31];
`endif
            if (op[0] && (b == 32'd0)) begin
              state <= DZERO;
            end else begin
              state <= CALC;
              m     <= op[0] ? mb : ma;
              acc   <= {32'd0, op[0] ? ma : mb};
            end
          end
        end
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
`ifdef MULDIV_SIGNED_EN
            if (sgn_q)
              state <= FIX;
            else
`endif
            begin
              state <= IDLE;
              hi    <= acc_nx[63:32];
              lo    <= acc_nx[31:0];
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        FIX: begin
          state <= IDLE;
          hi    <= fix_hi;
          lo    <= fix_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
`endif
        DZERO: begin
          state <= IDLE;
          hi    <= a_lat;
          lo    <= 32'hFFFF_FFFF;
          dz    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases, random ops against
// an arithmetic reference model, back-to-back, hold and reset-abort.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dz;

  int pass_cnt = 0;
  int total = 0;

`ifdef MULDIV_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [1:0] o, input logic [31:0] x,
                                input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz, output int elat);
    bit s;
    longint sx, sy, q, r;
    logic [63:0] p;
    s   = SEN && o[1];
    sx  = $signed(x);
    sy  = $signed(y);
    edz = 1'b0;
    if (o[0] && y == 32'd0) begin
      eh = x; el = 32'hFFFF_FFFF; edz = 1'b1; elat = 2;
      return;
    end
    elat = s ? 34 : 33;
    if (!o[0]) begin
      if (s) p = sx * sy;
      else   p = {32'd0, x} * {32'd0, y};
      eh = p[63:32]; el = p[31:0];
    end else if (s) begin
      q = sx / sy; r = sx % sy;
      el = q[31:0]; eh = r[31:0];
    end else begin
      el = x / y; eh = x % y;
    end
  endfunction

  // Issues one op and reports the latency (edges from the start edge, counted
  // as 1) at which done appeared; inputs are scrambled after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output logic rdz, output int lat, output bit busy_bad);
    rh = 'x; rl = 'x; rdz = 'x;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    lat = 0; busy_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      if (done) begin
        lat = k; rh = hi; rl = lo; rdz = dz;
        if (busy) busy_bad = 1'b1;
        break;
      end
      if (!busy) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else pass_cnt++;
    total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (dz !== 1'b0) $display("FAIL reset_dz got %b want 0", dz); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] rh, rl, eh, el;
    logic rdz, edz;
    int lat, elat;
    bit bb;
    logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [31:0] xs  [4] = '{32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFFD};
    logic [31:0] ys  [4] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd5};
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rdz, lat, bb);
    total++; if (rh !== 32'hFFFF_FFFE) $display("FAIL multu_max_hi got %h want fffffffe", rh); else pass_cnt++;
    total++; if (rl !== 32'h1) $display("FAIL multu_max_lo got %h want 00000001", rl); else pass_cnt++;
    total++; if (lat !== 33) $display("FAIL multu_max_lat got %0d want 33", lat); else pass_cnt++;
    total++; if (bb !== 1'b0) $display("FAIL multu_max_busy got %b want 0", bb); else pass_cnt++;
    do_op(2'b01, 32'h1234, 32'd0, rh, rl, rdz, lat, bb);
    total++; if (rh !== 32'h1234) $display("FAIL dz_hi got %h want 00001234", rh); else pass_cnt++;
    total++; if (rl !== 32'hFFFF_FFFF) $display("FAIL dz_lo got %h want ffffffff", rl); else pass_cnt++;
    total++; if (rdz !== 1'b1) $display("FAIL dz_flag got %b want 1", rdz); else pass_cnt++;
    total++; if (lat !== 2) $display("FAIL dz_lat got %0d want 2", lat); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      model(ops[i], xs[i], ys[i], eh, el, edz, elat);
      do_op(ops[i], xs[i], ys[i], rh, rl, rdz, lat, bb);
      total++; if (rh !== eh) $display("FAIL dir_hi op=%0d got %h want %h", ops[i], rh, eh); else pass_cnt++;
      total++; if (rl !== el) $display("FAIL dir_lo op=%0d got %h want %h", ops[i], rl, el); else pass_cnt++;
      total++; if (lat !== elat) $display("FAIL dir_lat op=%0d got %0d want %0d", ops[i], lat, elat); else pass_cnt++;
    end
`ifdef MULDIV_SIGNED_EN
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rdz, lat, bb);
    total++; if (rl !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", rl); else pass_cnt++;
    total++; if (rh !== 32'd0) $display("FAIL div_ovf_hi got %h want 0", rh); else pass_cnt++;
    total++; if (lat !== 34) $display("FAIL div_ovf_lat got %0d want 34", lat); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [31:0] rh, rl, eh, el, x, y;
    logic rdz, edz;
    logic [1:0] o;
    int lat, elat;
    bit bb;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      model(o, x, y, eh, el, edz, elat);
      do_op(o, x, y, rh, rl, rdz, lat, bb);
      total++; if (rh !== eh) $display("FAIL rnd_hi op=%0d a=%h b=%h got %h want %h", o, x, y, rh, eh); else pass_cnt++;
      total++; if (rl !== el) $display("FAIL rnd_lo op=%0d a=%h b=%h got %h want %h", o, x, y, rl, el); else pass_cnt++;
      total++; if (rdz !== edz) $display("FAIL rnd_dz op=%0d b=%h got %b want %b", o, y, rdz, edz); else pass_cnt++;
      total++; if (lat !== elat) $display("FAIL rnd_lat op=%0d got %0d want %0d", o, lat, elat); else pass_cnt++;
      total++; if (bb !== 1'b0) $display("FAIL rnd_busy op=%0d got %b want 0", o, bb); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
    seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
    end
    total++; if (seen !== 1'b1) $display("FAIL b2b_first_done got %b want 1", seen); else pass_cnt++;
    total++; if (lo !== 32'd14) $display("FAIL b2b_divu_lo got %0d want 14", lo); else pass_cnt++;
    total++; if (hi !== 32'd2) $display("FAIL b2b_divu_hi got %0d want 2", hi); else pass_cnt++;
    total++; if (dz !== 1'b0) $display("FAIL b2b_divu_dz got %b want 0", dz); else pass_cnt++;
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      if (done) begin lat = k; break; end
    end
    total++; if (lat !== 33) $display("FAIL b2b_lat got %0d want 33", lat); else pass_cnt++;
    total++; if (lo !== 32'd12) $display("FAIL b2b_multu_lo got %0d want 12", lo); else pass_cnt++;
    total++; if (hi !== 32'd0) $display("FAIL b2b_multu_hi got %0d want 0", hi); else pass_cnt++;
  endtask

  task automatic test_hold();
    logic [31:0] rh, rl, eh, el;
    logic rdz, edz;
    int lat, elat;
    bit bb;
    model(2'b01, 32'd1000, 32'd33, eh, el, edz, elat);
    do_op(2'b01, 32'd1000, 32'd33, rh, rl, rdz, lat, bb);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (done !== 1'b0) $display("FAIL hold_done cyc=%0d got %b want 0", k, done); else pass_cnt++;
      total++; if (hi !== eh) $display("FAIL hold_hi cyc=%0d got %h want %h", k, hi, eh); else pass_cnt++;
      total++; if (lo !== el) $display("FAIL hold_lo cyc=%0d got %h want %h", k, lo, el); else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    int dones;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
    dones = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      start = 1'b0;
      if (k == 5) begin start = 1'b1; op = 2'b01; a = 32'h55; b = 32'd0; end
      if (k == 7) begin
        total++; if (busy !== 1'b1) $display("FAIL abort_ignore_busy got %b want 1", busy); else pass_cnt++;
      end
    end
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
    total++; if (hi !== 32'd0) $display("FAIL abort_hi got %h want 0", hi); else pass_cnt++;
    total++; if (lo !== 32'd0) $display("FAIL abort_lo got %h want 0", lo); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL abort_no_done got %0d want 0", dones); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL abort_idle_busy got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
